// File: rtl/alu_result_tx.sv
// alu_result_tx: serialises one {carry, 10-bit result} from the ALU stage into
// a frame of 4-bit nibbles on a valid/ready output port.
// Optional feature macro: ALU_RESULT_TX_PARITY_EN appends a parity nibble
// {3'b101, even parity} to every frame (frame length 4 instead of 3).
module alu_result_tx #(
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [9:0]        res_q,
    input  logic              carry_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_data,
    output logic              out_last,
    output logic [1:0]        out_idx,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 11;
`ifdef ALU_RESULT_TX_PARITY_EN
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [FCNT_W-1:0]   cnt;
    logic [FCNT_W-1:0]   cnt_nxt;
    logic                last_c;
    logic                take_c;
    logic                accept_c;
    logic [NIB_W-1:0]    nib_c;

    // Handshake qualifiers: a new result may enter while idle or as the last nibble leaves
    assign last_c    = (state == SEND) && (idx == LAST_IDX);
    assign take_c    = (state == SEND) && out_ready;
    assign res_ready = (state == IDLE) || (take_c && last_c);
    assign accept_c  = res_valid && res_ready;

    // State, hold register, nibble index and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hold  <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: capture on accept, step the index on every nibble taken
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    hold_nxt  = {carry_q, res_q};
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (take_c) begin
                    if (!last_c) begin
                        idx_nxt = idx + IDX_W'(1);
                    end else begin
                        cnt_nxt = cnt + FCNT_W'(1);
                        if (accept_c) begin
                            hold_nxt = {carry_q, res_q};
                            idx_nxt  = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Nibble select from the registered hold value and index
    always_comb begin
        nib_c = '0;
        case (idx)
            2'd0:    nib_c = (MSB_FIRST != 0) ? {1'b0, hold[10:8]} : hold[3:0];
            2'd1:    nib_c = hold[7:4];
            2'd2:    nib_c = (MSB_FIRST != 0) ? hold[3:0] : {1'b0, hold[10:8]};
`ifdef ALU_RESULT_TX_PARITY_EN
            2'd3:    nib_c = {3'b101, ^hold};
`endif
            default: nib_c = '0;
        endcase
    end

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_data  = (state == SEND) ? nib_c : '0;
    assign out_last  = last_c;
    assign out_idx   = idx;
    assign frame_cnt = cnt;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: two instances (LSB-first and MSB-first) share the
// same inputs; a scoreboard of expected nibbles is filled on each accepted
// result and drained on each nibble handshake.
module tb_alu_result_tx;

    localparam int unsigned FCNT_W = 8;
`ifdef ALU_RESULT_TX_PARITY_EN
    localparam int unsigned L = 4;
`else
    localparam int unsigned L = 3;
`endif
    localparam logic [8:0] MASK_IDLE = 9'b1_1_1111_00_1;
    localparam logic [8:0] MASK_ALL  = 9'h1FF;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] idx;
        logic       last;
    } nib_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              res_valid;
    logic [9:0]        res_q;
    logic              carry_q;
    logic              out_ready;

    logic              res_ready_a, res_ready_b;
    logic              out_valid_a, out_valid_b;
    logic [3:0]        out_data_a, out_data_b;
    logic              out_last_a, out_last_b;
    logic [1:0]        out_idx_a, out_idx_b;
    logic              busy_a, busy_b;
    logic [FCNT_W-1:0] frame_cnt_a, frame_cnt_b;

    int                n_checks = 0;
    int                n_fail   = 0;
    nib_t              qa[$];
    nib_t              qb[$];
    logic [FCNT_W-1:0] exp_cnt;
    logic [8:0]        m;

    always #5 clk = ~clk;

    alu_result_tx #(.MSB_FIRST(0), .FCNT_W(FCNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready_a),
        .res_q(res_q), .carry_q(carry_q),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_last(out_last_a), .out_idx(out_idx_a),
        .busy(busy_a), .frame_cnt(frame_cnt_a)
    );

    alu_result_tx #(.MSB_FIRST(1), .FCNT_W(FCNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready_b),
        .res_q(res_q), .carry_q(carry_q),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_last(out_last_b), .out_idx(out_idx_b),
        .busy(busy_b), .frame_cnt(frame_cnt_b)
    );

    // Expected nibbles of one frame for both nibble orders
    function automatic void push_frame(input logic [9:0] r, input logic c);
        logic [3:0] n [4];
        nib_t       e;
        n[0] = r[3:0];
        n[1] = r[7:4];
        n[2] = {1'b0, c, r[9:8]};
        n[3] = {3'b101, ^{c, r}};
        for (int i = 0; i < 3; i++) begin
            e.idx  = 2'(i);
            e.last = (L == 3) && (i == 2);
            e.data = n[i];
            qa.push_back(e);
            e.data = n[2-i];
            qb.push_back(e);
        end
        if (L == 4) begin
            e.idx  = 2'd3;
            e.last = 1'b1;
            e.data = n[3];
            qa.push_back(e);
            qb.push_back(e);
        end
    endfunction

    function automatic logic [8:0] exp_a();
        if (qa.size() == 0) return 9'h000;
        return {1'b1, 1'b1, qa[0].data, qa[0].idx, qa[0].last};
    endfunction

    function automatic logic [8:0] exp_b();
        if (qb.size() == 0) return 9'h000;
        return {1'b1, 1'b1, qb[0].data, qb[0].idx, qb[0].last};
    endfunction

    function automatic logic exp_rdy();
        return (qa.size() == 0) || (out_ready && qa[0].last);
    endfunction

    function automatic logic [8:0] obs_a();
        return {out_valid_a, busy_a, out_data_a, out_idx_a, out_last_a};
    endfunction

    function automatic logic [8:0] obs_b();
        return {out_valid_b, busy_b, out_data_b, out_idx_b, out_last_b};
    endfunction

    task automatic drive(input logic rv, input logic [9:0] rq, input logic cq, input logic ordy);
        @(negedge clk);
        res_valid = rv;
        res_q     = rq;
        carry_q   = cq;
        out_ready = ordy;
        #1;
    endtask

    // Advance one clock and update the scoreboard from the driven inputs
    task automatic tick();
        logic       rdy, hs, v, cc;
        logic [9:0] r;
        rdy = exp_rdy();
        hs  = out_ready && (qa.size() > 0);
        v   = res_valid;
        r   = res_q;
        cc  = carry_q;
        @(posedge clk);
        if (hs) begin
            if (qa[0].last) exp_cnt++;
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        if (v && rdy) push_frame(r, cc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        res_valid = 1'b0; res_q = '0; carry_q = 1'b0; out_ready = 1'b0;
        qa.delete(); qb.delete(); exp_cnt = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (obs_a() !== 9'h000 || obs_b() !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%b b=%b want 0", obs_a(), obs_b());
        end
        n_checks++;
        if (frame_cnt_a !== '0 || frame_cnt_b !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: a=%0d b=%0d want 0", frame_cnt_a, frame_cnt_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (res_ready_a !== 1'b1 || res_ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: a=%b b=%b want 1", res_ready_a, res_ready_b);
        end
    endtask

    task automatic test_frame();
        for (int c = 0; c < int'(L) + 3; c++) begin
            drive(c == 0, 10'h2A5, 1'b1, 1'b1);
            m = (qa.size() > 0) ? MASK_ALL : MASK_IDLE;
            n_checks++;
            if ((obs_a() & m) !== (exp_a() & m) || (obs_b() & m) !== (exp_b() & m)) begin
                n_fail++;
                $display("FAIL frame_out c%0d: a=%b b=%b want a=%b b=%b", c, obs_a(), obs_b(), exp_a(), exp_b());
            end
            n_checks++;
            if (res_ready_a !== exp_rdy() || res_ready_b !== exp_rdy() || frame_cnt_a !== exp_cnt || frame_cnt_b !== exp_cnt) begin
                n_fail++;
                $display("FAIL frame_ctl c%0d: rdy=%b%b cnt=%0d/%0d want rdy=%b cnt=%0d", c, res_ready_a, res_ready_b, frame_cnt_a, frame_cnt_b, exp_rdy(), exp_cnt);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int   stall = 0;
        logic stalling;
        for (int c = 0; c < int'(L) + 9; c++) begin
            stalling = (qa.size() > 0) && (qa[0].idx == 2'd1) && (stall < 4);
            if (stalling) stall++;
            drive((c == 0) || stalling, (c == 0) ? 10'h2A5 : 10'($urandom), (c == 0) ? 1'b1 : 1'($urandom), !stalling);
            m = (qa.size() > 0) ? MASK_ALL : MASK_IDLE;
            n_checks++;
            if ((obs_a() & m) !== (exp_a() & m) || (obs_b() & m) !== (exp_b() & m)) begin
                n_fail++;
                $display("FAIL stall_out c%0d: a=%b b=%b want a=%b b=%b", c, obs_a(), obs_b(), exp_a(), exp_b());
            end
            n_checks++;
            if (res_ready_a !== exp_rdy() || res_ready_b !== exp_rdy() || frame_cnt_a !== exp_cnt || frame_cnt_b !== exp_cnt) begin
                n_fail++;
                $display("FAIL stall_ctl c%0d: rdy=%b%b cnt=%0d/%0d want rdy=%b cnt=%0d", c, res_ready_a, res_ready_b, frame_cnt_a, frame_cnt_b, exp_rdy(), exp_cnt);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic       sent2 = 1'b0;
        logic       rv;
        logic [9:0] rq;
        logic       cq;
        for (int c = 0; c < 2 * int'(L) + 3; c++) begin
            rv = 1'b0; rq = 10'h155; cq = 1'b1;
            if (c == 0) begin
                rv = 1'b1; rq = 10'h2A5; cq = 1'b1;
            end else if (!sent2 && qa.size() > 0 && qa[0].last) begin
                rv = 1'b1; rq = 10'h00F; cq = 1'b0; sent2 = 1'b1;
            end
            drive(rv, rq, cq, 1'b1);
            m = (qa.size() > 0) ? MASK_ALL : MASK_IDLE;
            n_checks++;
            if ((obs_a() & m) !== (exp_a() & m) || (obs_b() & m) !== (exp_b() & m)) begin
                n_fail++;
                $display("FAIL b2b_out c%0d: a=%b b=%b want a=%b b=%b", c, obs_a(), obs_b(), exp_a(), exp_b());
            end
            n_checks++;
            if (res_ready_a !== exp_rdy() || res_ready_b !== exp_rdy() || frame_cnt_a !== exp_cnt || frame_cnt_b !== exp_cnt) begin
                n_fail++;
                $display("FAIL b2b_ctl c%0d: rdy=%b%b cnt=%0d/%0d want rdy=%b cnt=%0d", c, res_ready_a, res_ready_b, frame_cnt_a, frame_cnt_b, exp_rdy(), exp_cnt);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        int c = 0;
        drive(1'b1, 10'h2A5, 1'b1, 1'b1);
        tick();
        while (!(qa.size() > 0 && qa[0].idx == 2'd1) && c < 10) begin
            drive(1'b0, 10'h000, 1'b0, 1'b1);
            tick();
            c++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        res_valid = 1'b0;
        #1;
        n_checks++;
        if (obs_a() !== 9'h000 || obs_b() !== 9'h000 || frame_cnt_a !== '0 || frame_cnt_b !== '0) begin
            n_fail++;
            $display("FAIL midreset: a=%b b=%b cnt=%0d/%0d want all 0", obs_a(), obs_b(), frame_cnt_a, frame_cnt_b);
        end
        qa.delete(); qb.delete(); exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < int'(L) + 3; k++) begin
            drive(k == 0, 10'h3C1, 1'b0, 1'b1);
            m = (qa.size() > 0) ? MASK_ALL : MASK_IDLE;
            n_checks++;
            if ((obs_a() & m) !== (exp_a() & m) || (obs_b() & m) !== (exp_b() & m)) begin
                n_fail++;
                $display("FAIL postreset_out c%0d: a=%b b=%b want a=%b b=%b", k, obs_a(), obs_b(), exp_a(), exp_b());
            end
            n_checks++;
            if (res_ready_a !== exp_rdy() || res_ready_b !== exp_rdy() || frame_cnt_a !== exp_cnt || frame_cnt_b !== exp_cnt) begin
                n_fail++;
                $display("FAIL postreset_ctl c%0d: rdy=%b%b cnt=%0d/%0d want rdy=%b cnt=%0d", k, res_ready_a, res_ready_b, frame_cnt_a, frame_cnt_b, exp_rdy(), exp_cnt);
            end
            tick();
        end
    endtask

    task automatic test_random_wrap();
        int   n_cyc = 400 * int'(L);
        logic live;
        for (int c = 0; c < n_cyc + int'(L) + 2; c++) begin
            live = (c < n_cyc);
            drive(live && ($urandom_range(0, 7) != 0), 10'($urandom), 1'($urandom),
                  !live || ($urandom_range(0, 3) != 0));
            m = (qa.size() > 0) ? MASK_ALL : MASK_IDLE;
            n_checks++;
            if ((obs_a() & m) !== (exp_a() & m) || (obs_b() & m) !== (exp_b() & m)) begin
                n_fail++;
                $display("FAIL rand_out c%0d: a=%b b=%b want a=%b b=%b", c, obs_a(), obs_b(), exp_a(), exp_b());
            end
            n_checks++;
            if (res_ready_a !== exp_rdy() || res_ready_b !== exp_rdy() || frame_cnt_a !== exp_cnt || frame_cnt_b !== exp_cnt) begin
                n_fail++;
                $display("FAIL rand_ctl c%0d: rdy=%b%b cnt=%0d/%0d want rdy=%b cnt=%0d", c, res_ready_a, res_ready_b, frame_cnt_a, frame_cnt_b, exp_rdy(), exp_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
